// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM states, RISC-V funct3
// access-size codes and a legality check for those codes.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } f3_e;

  // Stores only know b/h/w; loads additionally know the unsigned variants.
  function automatic logic f3Legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane logic for one 32-bit word: little-endian load extraction with
// sign/zero extension, and store data replication with byte enables.
module dmem_lane
  import mem_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] wword_o,
  output logic [3:0]  be_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Select the addressed lane, extend it for loads, and build the store lanes.
  always_comb begin
    byteSel = word_i[{addr_i, 3'b000} +: 8];
    halfSel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    rdata_o = '0;
    wword_o = '0;
    be_o    = '0;
    case (f3_i)
      F3_B: begin
        rdata_o = {{24{byteSel[7]}}, byteSel};
        wword_o = {4{wdata_i[7:0]}};
        be_o    = 4'b0001 << addr_i;
      end
      F3_H: begin
        rdata_o = {{16{halfSel[15]}}, halfSel};
        wword_o = {2{wdata_i[15:0]}};
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: begin
        rdata_o = word_i;
        wword_o = wdata_i;
        be_o    = 4'b1111;
      end
      F3_BU: rdata_o = {24'h0, byteSel};
      F3_HU: rdata_o = {16'h0, halfSel};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// then presents a held response. Define DMEM_MISALIGN_TRAP_EN to fault on
// misaligned halfword/word accesses; otherwise the low address bits are
// forced to alignment and the access completes.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e        state_q, state_d;
  logic [3:0]    waitCnt_q, waitCnt_d;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [2:0]    f3_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept;
  logic          enterResp;
  logic          memWe;
  logic          accWe;
  logic [31:0]   accAddr;
  logic [2:0]    accF3;
  logic [31:0]   accWdata;
  logic [1:0]    effLow;
  logic          outOfRange;
  logic          misalignFault;
  logic          fault;
  logic [IDX_W-1:0] wordIdx;
  logic [31:0]   curWord;
  logic [31:0]   laneRdata;
  logic [31:0]   laneWword;
  logic [3:0]   laneBe;

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live request fields are used instead of the captured copies.
  always_comb begin
    if (state_q == ST_IDLE) begin
      accWe    = req_we;
      accAddr  = req_addr;
      accF3    = req_f3;
      accWdata = req_wdata;
    end else begin
      accWe    = we_q;
      accAddr  = addr_q;
      accF3    = f3_q;
      accWdata = wdata_q;
    end
  end

  // Force halfword/word accesses onto their natural alignment.
  always_comb begin
    effLow = accAddr[1:0];
    case (accF3)
      F3_H, F3_HU: effLow = {accAddr[1], 1'b0};
      F3_W:        effLow = 2'b00;
      default:     ;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  // Flag halfword accesses on odd bytes and word accesses off a word boundary.
  always_comb begin
    misalignFault = 1'b0;
    case (accF3)
      F3_H, F3_HU: misalignFault = accAddr[0];
      F3_W:        misalignFault = |accAddr[1:0];
      default:     ;
    endcase
  end
`else
  assign misalignFault = 1'b0;
`endif

  assign outOfRange = accAddr[31:2] >= 30'(DEPTH_WORDS);
  assign fault      = !f3Legal(accWe, accF3) || outOfRange || misalignFault;
  assign wordIdx    = accAddr[IDX_W+1:2];
  assign curWord    = mem_q[wordIdx];

  dmem_lane u_lane (
    .f3_i    (accF3),
    .addr_i  (effLow),
    .word_i  (curWord),
    .wdata_i (accWdata),
    .rdata_o (laneRdata),
    .wword_o (laneWword),
    .be_o    (laneBe)
  );

  // Next-state logic; the response is latched on the edge entering RESP.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    accept    = 1'b0;
    enterResp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          waitCnt_d = '0;
          if (WAIT_CYCLES == 0) begin
            state_d   = ST_RESP;
            enterResp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (waitCnt_q == 4'(WAIT_CYCLES - 1)) begin
          state_d   = ST_RESP;
          enterResp = 1'b1;
          waitCnt_d = '0;
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enterResp) begin
      err_d   = fault;
      rdata_d = (fault || accWe) ? '0 : laneRdata;
    end
  end

  // State, counter, response and captured request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      f3_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        f3_q    <= req_f3;
        wdata_q <= req_wdata;
      end
    end
  end

  // A store commits only on a fault-free edge into RESP outside reset.
  assign memWe = enterResp && accWe && !fault && rst;

  // Storage has no reset; only the enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (laneBe[b]) begin
          mem_q[wordIdx][8*b +: 8] <= laneWword[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a vector table applied in a loop
// with a response scoreboard, plus back-pressure and mid-operation reset
// sequences. Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WAITS = 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_f3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  vec_t vecs[$];
  exp_t sbQ[$];
  int   totalChecks = 0;
  int   passChecks  = 0;
  int   rspCount    = 0;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_f3    (req_f3),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string what, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual === expected) passChecks++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", what, actual, expected);
  endtask

  task automatic reportTimeout(input string what);
    totalChecks++;
    $display("[TB] FAIL %s: timed out waiting on DUT", what);
  endtask

  task automatic addVec(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wdata, input logic [31:0] expRdata,
                        input logic expErr);
    vec_t v;
    v.we = we; v.addr = addr; v.f3 = f3; v.wdata = wdata;
    v.expRdata = expRdata; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  // Scoreboard side: every response handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      rspCount++;
      if (sbQ.size() == 0) begin
        totalChecks++;
        $display("[TB] FAIL unexpected response: rdata 0x%08h err %0b", rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput($sformatf("rsp%0d rdata", rspCount), rsp_rdata, e.rdata);
        checkOutput($sformatf("rsp%0d err", rspCount), {31'h0, rsp_err}, {31'h0, e.err});
      end
    end
  end

  // Present a request, hold it until accepted, then queue its expectation.
  task automatic sendReq(input vec_t v, input bit expectRsp, output bit ok);
    int guard;
    req_we = v.we; req_addr = v.addr; req_f3 = v.f3; req_wdata = v.wdata;
    req_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready && guard < 50);
    ok = req_ready;
    if (!ok) begin
      req_valid = 1'b0;
      reportTimeout("request acceptance");
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (expectRsp) sbQ.push_back('{rdata: v.expRdata, err: v.expErr});
  endtask

  // Count edges from acceptance until rsp_valid is seen.
  task automatic waitRsp(output int lat, output bit ok);
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!ok) reportTimeout("response valid");
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    bit ok;
    sendReq(v, 1'b1, ok);
    if (!ok) return;
    waitRsp(lat, ok);
    if (!ok) return;
    checkOutput({tag, " latency"}, lat, WAITS + 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    bit ok;
    vec_t v;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_f3 = '0; req_wdata = '0; rsp_ready = 1'b1;

    // Load/store table: write, byte/half extension, faults.
    addVec(1, 32'h10,  3'b010, 32'hDEADBEEF, 32'h0,        0);
    addVec(0, 32'h10,  3'b010, 32'h0,        32'hDEADBEEF, 0);
    addVec(1, 32'h13,  3'b000, 32'h00000080, 32'h0,        0);
    addVec(0, 32'h13,  3'b000, 32'h0,        32'hFFFFFF80, 0);
    addVec(0, 32'h13,  3'b100, 32'h0,        32'h00000080, 0);
    addVec(0, 32'h10,  3'b010, 32'h0,        32'h80ADBEEF, 0);
    addVec(0, 32'h10,  3'b001, 32'h0,        32'hFFFFBEEF, 0);
    addVec(0, 32'h12,  3'b101, 32'h0,        32'h000080AD, 0);
    addVec(0, 32'h10,  3'b000, 32'h0,        32'hFFFFFFEF, 0);
    addVec(0, 32'h11,  3'b100, 32'h0,        32'h000000BE, 0);
    addVec(1, 32'h16,  3'b001, 32'h1234ABCD, 32'h0,        0);
    addVec(0, 32'h16,  3'b101, 32'h0,        32'h0000ABCD, 0);
    addVec(0, 32'h16,  3'b001, 32'h0,        32'hFFFFABCD, 0);
    addVec(0, 32'h17,  3'b100, 32'h0,        32'h000000AB, 0);
    addVec(0, 32'h16,  3'b000, 32'h0,        32'hFFFFFFCD, 0);
    addVec(1, 32'h3FC, 3'b010, 32'hCAFEF00D, 32'h0,        0);
    addVec(0, 32'h3FC, 3'b010, 32'h0,        32'hCAFEF00D, 0);
    addVec(0, 32'h400, 3'b010, 32'h0,        32'h0,        1);
    addVec(0, 32'hFFFFFFF0, 3'b010, 32'h0,   32'h0,        1);
    addVec(1, 32'h410, 3'b010, 32'h0,        32'h0,        1);
    addVec(1, 32'h10,  3'b011, 32'h0,        32'h0,        1);
    addVec(1, 32'h10,  3'b100, 32'h0,        32'h0,        1);
    addVec(0, 32'h10,  3'b011, 32'h0,        32'h0,        1);
    addVec(0, 32'h10,  3'b110, 32'h0,        32'h0,        1);
    addVec(0, 32'h10,  3'b111, 32'h0,        32'h0,        1);
    addVec(0, 32'h10,  3'b010, 32'h0,        32'h80ADBEEF, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    addVec(0, 32'h11,  3'b001, 32'h0,        32'h0,        1);
    addVec(0, 32'h12,  3'b010, 32'h0,        32'h0,        1);
    addVec(1, 32'h11,  3'b001, 32'h00005555, 32'h0,        1);
`else
    addVec(0, 32'h11,  3'b001, 32'h0,        32'hFFFFBEEF, 0);
    addVec(0, 32'h12,  3'b010, 32'h0,        32'h80ADBEEF, 0);
    addVec(1, 32'h11,  3'b001, 32'h00005555, 32'h0,        0);
`endif
    addVec(0, 32'h10,  3'b010, 32'h0,
`ifdef DMEM_MISALIGN_TRAP_EN
           32'h80ADBEEF,
`else
           32'h80AD5555,
`endif
           0);

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset rsp_err", {31'h0, rsp_err}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: response held for five cycles with rsp_ready low.
    rsp_ready = 1'b0;
    v.we = 0; v.addr = 32'h3FC; v.f3 = 3'b010; v.wdata = 0;
    v.expRdata = 32'hCAFEF00D; v.expErr = 0;
    sendReq(v, 1'b1, ok);
    if (ok) waitRsp(lat, ok);
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput($sformatf("bp%0d rsp_valid", i), {31'h0, rsp_valid}, 32'h1);
        checkOutput($sformatf("bp%0d rsp_rdata", i), rsp_rdata, 32'hCAFEF00D);
        checkOutput($sformatf("bp%0d req_ready", i), {31'h0, req_ready}, 32'h0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp release req_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("bp release rsp_valid", {31'h0, rsp_valid}, 32'h0);
    end
    rsp_ready = 1'b1;

    // Reset during WAIT drops the pending store.
    v.we = 1; v.addr = 32'h20; v.f3 = 3'b010; v.wdata = 32'h11111111;
    v.expRdata = 0; v.expErr = 0;
    applyStimulus(v, "rst pre-store");
    v.wdata = 32'h22222222;
    sendReq(v, 1'b0, ok);
    if (ok) begin
      rst = 1'b0;
      #1;
      checkOutput("midrst req_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("midrst rsp_valid", {31'h0, rsp_valid}, 32'h0);
      checkOutput("midrst rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("midrst rsp_err", {31'h0, rsp_err}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst held rsp_valid", {31'h0, rsp_valid}, 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
    end
    v.we = 0; v.wdata = 0; v.expRdata = 32'h11111111;
    applyStimulus(v, "rst post-load");

    repeat (3) @(posedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 32'h0);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
